fifo_port_arbiter: RTL and testbench

Sequencer and arbiter that shares the 8-entry × 4-bit FIFO between two producers and two consumers. It owns the FIFO's `enq`, `deq` and `in` inputs. It observes the FIFO's `out`, `emp` and `full` outputs. It serialises every access into single-cycle enqueue/dequeue pulses that are separated by an idle cycle, as the FIFO's edge-based control requires. Arbitration is round-robin within each direction, and enqueue and dequeue alternate when both are pending.

---
 rtl/fifo_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_fifo_port_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_port_arbiter.sv
// rtl/fifo_port_arbiter.sv - two-producer / two-consumer sequencer for a shared 8x4 FIFO
//
// Serialises FIFO accesses into single-cycle enq/deq pulses. Each pulse is
// followed by an idle cycle, because the FIFO's control is edge based.
// Producers and consumers are each arbitrated round-robin. When both an
// enqueue and a dequeue are eligible, the two directions take turns.
//
// Ports:
//   clk                 rising-edge clock
//   rst                 asynchronous active-low reset
//   req_enq[1:0]        producer requests, held until the matching ack_enq
//   din0, din1          producer data, stable while its request is high
//   ack_enq[1:0]        one-cycle pulse while that producer's data is written
//   req_deq[1:0]        consumer requests, held until the matching dvalid
//   dout                registered dequeued data
//   dvalid[1:0]         one-cycle pulse marking dout for that consumer
//   fifo_enq, fifo_deq  FIFO control pulses
//   fifo_in             FIFO write data
//   fifo_out            FIFO head data (combinational, valid when !fifo_emp)
//   fifo_emp, fifo_full FIFO status flags
//   busy                high in every state except IDLE

module fifo_port_arbiter #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req_enq,
    input  logic [DW-1:0] din0,
    input  logic [DW-1:0] din1,
    output logic [1:0]    ack_enq,
    input  logic [1:0]    req_deq,
    output logic [DW-1:0] dout,
    output logic [1:0]    dvalid,
    output logic          fifo_enq,
    output logic          fifo_deq,
    output logic [DW-1:0] fifo_in,
    input  logic [DW-1:0] fifo_out,
    input  logic          fifo_emp,
    input  logic          fifo_full,
    output logic          busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ENQ  = 2'd1;
    localparam logic [1:0] S_DEQ  = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    localparam logic OP_DEQ = 1'b0;
    localparam logic OP_ENQ = 1'b1;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic          last_op;
    logic          rr_e;
    logic          rr_d;
    logic          sel_e;
    logic          sel_d;
    logic [DW-1:0] fifo_in_q;
    logic [DW-1:0] dout_q;
    logic [1:0]    dvalid_q;

    logic          ev;
    logic          dv;
    logic          go_enq;
    logic          go_deq;
    logic          pick_e;
    logic          pick_d;

    // Flags are only looked at in IDLE. This block is the FIFO's only
    // accessor, so they have settled by the time the GAP cycle has passed.
    assign ev = (|req_enq) & ~fifo_full;
    assign dv = (|req_deq) & ~fifo_emp;

    // When both directions are eligible, the direction not used last time wins.
    assign go_enq = ev & (~dv | (last_op == OP_DEQ));
    assign go_deq = dv & ~go_enq;

    // The round-robin pointer only matters when both sides request.
    // Otherwise the single requester wins.
    assign pick_e = (req_enq == 2'b11) ? rr_e : req_enq[1];
    assign pick_d = (req_deq == 2'b11) ? rr_d : req_deq[1];

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (go_enq) begin
                    state_nxt = S_ENQ;
                end else if (go_deq) begin
                    state_nxt = S_DEQ;
                end
            end
            S_ENQ:   state_nxt = S_GAP;
            S_DEQ:   state_nxt = S_GAP;
            S_GAP:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant bookkeeping happens on the edge that leaves IDLE. Write data is
    // captured there too, so fifo_in is already stable during the ENQ pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_e      <= 1'b0;
            rr_d      <= 1'b0;
            sel_e     <= 1'b0;
            sel_d     <= 1'b0;
            fifo_in_q <= '0;
        end else if (state == S_IDLE) begin
            if (go_enq) begin
                sel_e     <= pick_e;
                rr_e      <= ~pick_e;
                fifo_in_q <= pick_e ? din1 : din0;
            end else if (go_deq) begin
                sel_d <= pick_d;
                rr_d  <= ~pick_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_op <= OP_DEQ;
        end else if (state == S_ENQ) begin
            last_op <= OP_ENQ;
        end else if (state == S_DEQ) begin
            last_op <= OP_DEQ;
        end
    end

    // The head is captured on the same edge on which the FIFO pops it.
    // dvalid is therefore high only during the GAP that follows a DEQ.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_q   <= '0;
            dvalid_q <= 2'b00;
        end else if (state == S_DEQ) begin
            dout_q   <= fifo_out;
            dvalid_q <= sel_d ? 2'b10 : 2'b01;
        end else begin
            dvalid_q <= 2'b00;
        end
    end

    // Control pulses decode the state directly. A reset therefore drops
    // them immediately, even in the middle of a cycle.
    assign fifo_enq = (state == S_ENQ);
    assign fifo_deq = (state == S_DEQ);
    assign ack_enq  = fifo_enq ? (sel_e ? 2'b10 : 2'b01) : 2'b00;
    assign busy     = (state != S_IDLE);
    assign fifo_in  = fifo_in_q;
    assign dout     = dout_q;
    assign dvalid   = dvalid_q;

endmodule

// File: tb/tb_fifo_port_arbiter.sv
// tb/tb_fifo_port_arbiter.sv - self-checking bench for fifo_port_arbiter
module tb_fifo_port_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] req_enq = 2'b00;
    logic [3:0] din0 = 4'h0;
    logic [3:0] din1 = 4'h0;
    logic [1:0] ack_enq;
    logic [1:0] req_deq = 2'b00;
    logic [3:0] dout;
    logic [1:0] dvalid;
    logic       fifo_enq;
    logic       fifo_deq;
    logic [3:0] fifo_in;
    logic [3:0] fifo_out;
    logic       fifo_emp;
    logic       fifo_full;
    logic       busy;

    always #5 clk = ~clk;

    fifo_port_arbiter #(.DW(4)) dut (
        .clk(clk), .rst(rst),
        .req_enq(req_enq), .din0(din0), .din1(din1), .ack_enq(ack_enq),
        .req_deq(req_deq), .dout(dout), .dvalid(dvalid),
        .fifo_enq(fifo_enq), .fifo_deq(fifo_deq), .fifo_in(fifo_in),
        .fifo_out(fifo_out), .fifo_emp(fifo_emp), .fifo_full(fifo_full),
        .busy(busy)
    );

    // ---------------- FIFO stand-in (8 x 4, acts on the control pulses)
    logic [3:0] mem [0:7];
    logic [2:0] wp, rp;
    logic [3:0] fcnt;
    assign fifo_out  = mem[rp];
    assign fifo_emp  = (fcnt == 4'd0);
    assign fifo_full = (fcnt == 4'd8);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp <= '0; rp <= '0; fcnt <= '0;
        end else begin
            if (fifo_enq && fcnt < 4'd8) begin
                mem[wp] <= fifo_in;
                wp <= wp + 3'd1;
            end
            if (fifo_deq && fcnt > 4'd0) rp <= rp + 3'd1;
            fcnt <= fcnt + {3'd0, fifo_enq && fcnt < 4'd8} - {3'd0, fifo_deq && fcnt > 4'd0};
        end
    end

    // ---------------- checking
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference
    // Each access is an idle, an access and a gap phase. The model tracks the
    // occupancy and the queue of written data itself.
    int         mph;
    logic       mkind;
    logic       mwho;
    logic [3:0] mdata, mexp_dout;
    logic       mrr_e, mrr_d, mlast_enq;
    int         mocc;
    logic [3:0] sb [$];

    wire m_ev     = (|req_enq) && (mocc < 8);
    wire m_dv     = (|req_deq) && (mocc > 0);
    wire m_enq    = m_ev && (!m_dv || !mlast_enq);
    wire m_pick_e = (req_enq == 2'b11) ? mrr_e : req_enq[1];
    wire m_pick_d = (req_deq == 2'b11) ? mrr_d : req_deq[1];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mph <= 0; mkind <= 1'b0; mwho <= 1'b0; mdata <= '0; mexp_dout <= '0;
            mrr_e <= 1'b0; mrr_d <= 1'b0; mlast_enq <= 1'b0; mocc <= 0;
            sb.delete();
        end else if (mph == 0) begin
            if (m_enq) begin
                mph <= 1; mkind <= 1'b1; mwho <= m_pick_e; mrr_e <= ~m_pick_e;
                mdata <= m_pick_e ? din1 : din0;
            end else if (m_dv) begin
                mph <= 1; mkind <= 1'b0; mwho <= m_pick_d; mrr_d <= ~m_pick_d;
            end
        end else if (mph == 1) begin
            mph <= 2;
            if (mkind) begin
                mocc <= mocc + 1; sb.push_back(mdata); mlast_enq <= 1'b1;
            end else begin
                mocc <= mocc - 1; mexp_dout <= sb.pop_front(); mlast_enq <= 1'b0;
            end
        end else begin
            mph <= 0;
        end
    end

    wire       e_enq  = (mph == 1) && mkind;
    wire       e_deq  = (mph == 1) && !mkind;
    wire       e_dvf  = (mph == 2) && !mkind;
    wire [1:0] e_ack  = e_enq ? (mwho ? 2'b10 : 2'b01) : 2'b00;
    wire [1:0] e_dv   = e_dvf ? (mwho ? 2'b10 : 2'b01) : 2'b00;

    always @(negedge clk) begin
        chk("fifo_enq", {31'd0, fifo_enq}, {31'd0, e_enq});
        chk("fifo_deq", {31'd0, fifo_deq}, {31'd0, e_deq});
        chk("ack_enq", {30'd0, ack_enq}, {30'd0, e_ack});
        chk("dvalid", {30'd0, dvalid}, {30'd0, e_dv});
        chk("busy", {31'd0, busy}, {31'd0, mph != 0});
        chk("enq_deq_excl", {31'd0, fifo_enq & fifo_deq}, 32'd0);
        if (e_enq) chk("fifo_in", {28'd0, fifo_in}, {28'd0, mdata});
        if (e_dvf) chk("dout", {28'd0, dout}, {28'd0, mexp_dout});
    end

    // ---------------- producer / consumer agents and event logs
    logic [3:0] pq0 [$];
    logic [3:0] pq1 [$];
    int         cd [2];
    int         cyc = 0;
    int         ack_idx [$];
    int         ack_t [$];
    int         dv_idx [$];
    logic [3:0] dv_data [$];
    bit         oplog [$];
    int         enq_cnt = 0;
    bit         trk = 1'b0;
    int         occ_min, occ_max;

    task automatic drive();
        req_enq = {pq1.size() > 0, pq0.size() > 0};
        din0    = (pq0.size() > 0) ? pq0[0] : 4'h0;
        din1    = (pq1.size() > 0) ? pq1[0] : 4'h0;
        req_deq = {cd[1] > 0, cd[0] > 0};
    endtask

    task automatic tick();
        logic [1:0] s_ack, s_dv;
        @(negedge clk);
        cyc++;
        s_ack = ack_enq;
        s_dv  = dvalid;
        if (fifo_enq) begin enq_cnt++; oplog.push_back(1'b1); end
        if (fifo_deq) oplog.push_back(1'b0);
        if (trk) begin
            if (int'(fcnt) < occ_min) occ_min = int'(fcnt);
            if (int'(fcnt) > occ_max) occ_max = int'(fcnt);
        end
        for (int i = 0; i < 2; i++) begin
            if (s_ack[i]) begin ack_idx.push_back(i); ack_t.push_back(cyc); end
            if (s_dv[i]) begin dv_idx.push_back(i); dv_data.push_back(dout); end
        end
        @(posedge clk);
        #1;
        if (s_ack[0] && pq0.size() > 0) void'(pq0.pop_front());
        if (s_ack[1] && pq1.size() > 0) void'(pq1.pop_front());
        for (int i = 0; i < 2; i++) if (s_dv[i] && cd[i] > 0) cd[i]--;
        drive();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_acks(input int n, input int budget);
        int b = 0;
        while (ack_idx.size() < n && b < budget) begin tick(); b++; end
        chk("ack_wait", ack_idx.size(), n);
    endtask

    task automatic wait_dv(input int n, input int budget);
        int b = 0;
        while (dv_idx.size() < n && b < budget) begin tick(); b++; end
        chk("dv_wait", dv_idx.size(), n);
    endtask

    task automatic clear_all();
        pq0.delete(); pq1.delete(); cd[0] = 0; cd[1] = 0;
        ack_idx.delete(); ack_t.delete(); dv_idx.delete(); dv_data.delete();
        oplog.delete(); enq_cnt = 0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_all();
        drive();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with requests active; all outputs stay at zero.
        clear_all();
        pq0.push_back(4'h9);
        cd[0] = 1;
        drive();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_outs", {20'd0, fifo_enq, fifo_deq, ack_enq, dvalid, dout, fifo_in}, 32'd0);
        end
        cd[0] = 0;
        drive();
        rst = 1'b1;
        enq_cnt = 0;
        run(12);
        chk("first_enq_pulses", enq_cnt, 1);
        chk("first_ack_cycle", (ack_t.size() > 0) ? ack_t[0] - 3 : -1, 2);
        chk("first_occ", {28'd0, fcnt}, 32'd1);

        // Single producer fill, then a ninth request waits for a dequeue.
        do_reset();
        for (int k = 1; k <= 9; k++) pq0.push_back(4'(k));
        drive();
        wait_acks(8, 40);
        for (int k = 1; k < 8; k++) chk("ack_spacing", ack_t[k] - ack_t[k-1], 3);
        run(15);
        chk("full_no_ack", ack_idx.size(), 8);
        chk("full_flag", {31'd0, fifo_full}, 32'd1);
        cd[0] = 1;
        drive();
        wait_dv(1, 20);
        chk("fill_first_out", {28'd0, dv_data[0]}, 32'd1);
        wait_acks(9, 20);
        chk("ninth_written", {28'd0, fcnt}, 32'd8);

        // Round-robin enqueue, then drain in order.
        do_reset();
        pq0.push_back(4'hA); pq0.push_back(4'hA);
        pq1.push_back(4'h5); pq1.push_back(4'h5);
        drive();
        wait_acks(4, 40);
        for (int k = 0; k < 4; k++) chk("rr_order", ack_idx[k], k % 2);
        cd[0] = 4;
        drive();
        wait_dv(4, 40);
        for (int k = 0; k < 4; k++) chk("rr_drain", {28'd0, dv_data[k]}, (k % 2) ? 32'h5 : 32'hA);

        // Drain order and empty wait for consumer 1.
        do_reset();
        pq0.push_back(4'h3); pq0.push_back(4'h7); pq0.push_back(4'hC);
        drive();
        wait_acks(3, 30);
        cd[1] = 4;
        drive();
        wait_dv(3, 30);
        chk("drain0", {28'd0, dv_data[0]}, 32'h3);
        chk("drain1", {28'd0, dv_data[1]}, 32'h7);
        chk("drain2", {28'd0, dv_data[2]}, 32'hC);
        chk("drain_idx", dv_idx[0] + dv_idx[1] + dv_idx[2], 3);
        run(15);
        chk("empty_wait", dv_idx.size(), 3);
        chk("empty_flag", {31'd0, fifo_emp}, 32'd1);
        chk("empty_idle", {31'd0, busy}, 32'd0);

        // Simultaneous enqueue/dequeue starting from two entries, last op DEQ.
        do_reset();
        pq0.push_back(4'h1); pq0.push_back(4'h2); pq0.push_back(4'h3);
        drive();
        wait_acks(3, 30);
        cd[0] = 1;
        drive();
        wait_dv(1, 20);
        oplog.delete();
        occ_min = 99; occ_max = -1; trk = 1'b1;
        pq0.push_back(4'h4); pq0.push_back(4'h5); pq0.push_back(4'h6);
        cd[0] = 3;
        drive();
        wait_dv(4, 40);
        trk = 1'b0;
        chk("alt_len", oplog.size(), 6);
        for (int k = 0; k < 6; k++) chk("alt_order", {31'd0, oplog[k]}, (k % 2 == 0) ? 32'd1 : 32'd0);
        chk("alt_occ_min", occ_min, 2);
        chk("alt_occ_max", occ_max, 3);
        chk("alt_data", {16'd0, dv_data[1], dv_data[2], dv_data[3], 4'h0}, 32'h2340);

        // Reset in the middle of a DEQ cycle.
        do_reset();
        pq0.push_back(4'h6); pq0.push_back(4'h9);
        drive();
        wait_acks(2, 20);
        cd[0] = 1; cd[1] = 1;
        drive();
        begin
            int b = 0;
            while (!fifo_deq && b < 20) begin @(posedge clk); #1; b++; end
            chk("deq_seen", {31'd0, fifo_deq}, 32'd1);
        end
        #2 rst = 1'b0;
        #1;
        chk("abort_deq", {31'd0, fifo_deq}, 32'd0);
        chk("abort_dvalid", {30'd0, dvalid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        dv_idx.delete(); dv_data.delete();
        run(6);
        chk("abort_no_dv", dv_idx.size(), 0);
        pq0.push_back(4'h1); pq0.push_back(4'h2);
        drive();
        wait_dv(2, 40);
        chk("rr_d_reset", dv_idx[0], 0);
        chk("post_abort_data", {28'd0, dv_data[0]}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
